// File: rtl/sram_port_arbiter.sv
// Front-end for a single-port FIFO SRAM: round-robin arbitration between two writers,
// one reader, occupancy tracking, and an overflow error state that blocks all traffic.
module sram_port_arbiter #(
  parameter int BITS       = 12,
  parameter int word_depth = 8,
  parameter int addr_width = 3,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [BITS-1:0]       req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [BITS-1:0]       req1_data,
  output logic                  req1_ready,
  input  logic                  rd_req,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [BITS-1:0]       rd_data,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [BITS-1:0]       mem_data_in,
  input  logic [BITS-1:0]       mem_data_out,
  input  logic                  mem_overflow,
  input  logic                  clr_err,
  output logic [addr_width:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  err_overflow,
  output logic                  last_grant
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_ERROR = 1'b1} state_t;

  localparam logic [addr_width:0] DEPTH = (addr_width + 1)'(word_depth);
  localparam logic [addr_width:0] ONE   = {{addr_width{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [addr_width:0] r_count;
  logic [addr_width:0] w_count_nxt;
  logic                r_last_grant;
  logic                r_mem_write;
  logic                r_mem_read;
  logic [BITS-1:0]     r_mem_data_in;
  logic [BITS-1:0]     r_rd_data;
  logic [RD_LAT-1:0]   r_rd_sr;
  logic [RD_LAT:0]     w_lat;
  logic                w_run;
  logic                w_full;
  logic                w_empty;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_wr_acc;
  logic                w_rd_acc;

  assign w_run   = (r_state == ST_RUN);
  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == {(addr_width + 1){1'b0}});

  // r_last_grant=1 means writer 1 won last, so writer 0 has priority on a tie
  assign w_gnt0   = w_run && !w_full && req0_valid && (!req1_valid || r_last_grant);
  assign w_gnt1   = w_run && !w_full && req1_valid && (!req0_valid || !r_last_grant);
  assign w_wr_acc = w_gnt0 || w_gnt1;
  assign w_rd_acc = rd_req && !w_empty && w_run;

  // bit 0 is the live mem_read; bit RD_LAT-1 marks the cycle mem_data_out is sampled
  assign w_lat = {r_rd_sr, r_mem_read};

  // Next-state logic for the RUN/ERROR controller
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (mem_overflow) w_state_nxt = ST_ERROR;
        else              w_state_nxt = ST_RUN;
      end
      ST_ERROR: begin
        if (clr_err) w_state_nxt = ST_RUN;
        else         w_state_nxt = ST_ERROR;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Occupancy update; simultaneous write and read cancel out
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + ONE;
      2'b01:   w_count_nxt = r_count - ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // State, counters, SRAM strobes and read-return pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_count       <= {(addr_width + 1){1'b0}};
      r_last_grant  <= 1'b1;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_data_in <= {BITS{1'b0}};
      r_rd_data     <= {BITS{1'b0}};
      r_rd_sr       <= {RD_LAT{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_mem_write <= w_wr_acc;
      r_mem_read  <= w_rd_acc;
      r_rd_sr     <= w_lat[RD_LAT-1:0];
      if (w_wr_acc) r_last_grant <= w_gnt1;
      if (w_gnt1)      r_mem_data_in <= req1_data;
      else if (w_gnt0) r_mem_data_in <= req0_data;
      if (w_lat[RD_LAT-1]) r_rd_data <= mem_data_out;
    end
  end

  assign req0_ready   = w_gnt0;
  assign req1_ready   = w_gnt1;
  assign rd_ready     = w_rd_acc;
  assign rd_valid     = r_rd_sr[RD_LAT-1];
  assign rd_data      = r_rd_data;
  assign mem_write    = r_mem_write;
  assign mem_read     = r_mem_read;
  assign mem_data_in  = r_mem_data_in;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign err_overflow = (r_state == ST_ERROR);
  assign last_grant   = r_last_grant;

endmodule
